// File: rtl/reg_rd_pkg.sv
// reg_rd_pkg: shared constants and types for the register read port.
//   DATA_W_DEF / DEPTH_DEF : default data width and capture queue depth
//   occ_t                  : queue occupancy state (EMPTY, PARTIAL, FULL)
//   occ_of()               : maps a level onto an occupancy state
package reg_rd_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } occ_t;

    function automatic occ_t occ_of(input int level, input int depth);
        if (level == 0)          return EMPTY;
        else if (level >= depth) return FULL;
        else                     return PARTIAL;
    endfunction

endpackage

// File: rtl/reg_rd_fifo.sv
// reg_rd_fifo: first-word-fall-through sample queue with wrapping pointers.
//   clk, rst_n : clock, asynchronous active-low reset
//   push/wdata : write request; ignored when FULL unless a pop happens too
//   pop        : head consumed this cycle; ignored when EMPTY
//   rdata      : head sample, forced to zero while EMPTY
//   level/occ  : number of queued samples and its occupancy state
module reg_rd_fifo
    import reg_rd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       pop,
    output logic [DATA_W-1:0]          rdata,
    output logic [$clog2(DEPTH):0]     level,
    output occ_t                       occ
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr, rptr;
    logic [PTR_W:0]    count;
    logic              wr_ok, rd_ok;

    assign occ   = occ_of(int'(count), DEPTH);
    assign level = count;

    // A pop frees the head slot in the same cycle, so FULL still accepts a push.
    assign rd_ok = pop && (occ != EMPTY);
    assign wr_ok = push && ((occ != FULL) || rd_ok);

    // Storage is not reset; rdata masks it while nothing is queued.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr] <= wdata;
    end

    assign rdata = (occ != EMPTY) ? mem[rptr] : '0;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/reg_read_port.sv
// reg_read_port: captures an upstream register's post-write value on every
// update pulse and queues it for a valid/ready consumer.
//   iClk, iRst_n      : clock, asynchronous active-low reset
//   iUpd, iRegData    : write pulse and register read value (sampled a cycle later)
//   oRdValid/oRdData  : head sample, iRdReady pops it
//   oLevel            : queued sample count
//   oOvf, iOvfClr     : sticky overflow (sample dropped while FULL), clear
// Build option: REG_READ_PORT_CHG_FILTER_EN skips captures equal to the last
// value pushed (the first capture after reset is always pushed).
module reg_read_port
    import reg_rd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                   iClk,
    input  logic                   iRst_n,
    input  logic                   iUpd,
    input  logic [DATA_W-1:0]      iRegData,
    output logic                   oRdValid,
    output logic [DATA_W-1:0]      oRdData,
    input  logic                   iRdReady,
    output logic [$clog2(DEPTH):0] oLevel,
    output logic                   oOvf,
    input  logic                   iOvfClr
);
    logic upd_d;     // pending capture: register value settles the cycle after iUpd
    logic push, pop, ovf_set;
    occ_t occ;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) upd_d <= 1'b0;
        else         upd_d <= iUpd;
    end

    assign pop = oRdValid && iRdReady;

`ifdef REG_READ_PORT_CHG_FILTER_EN
    logic [DATA_W-1:0] last_val;
    logic              last_vld;
    logic              accepted;

    assign push     = upd_d && !(last_vld && (iRegData == last_val));
    // Only a sample that actually entered the queue counts as "last pushed".
    assign accepted = push && ((occ != FULL) || pop);

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            last_val <= '0;
            last_vld <= 1'b0;
        end else if (accepted) begin
            last_val <= iRegData;
            last_vld <= 1'b1;
        end
    end
`else
    assign push = upd_d;
`endif

    assign ovf_set = push && (occ == FULL) && !pop;

    // Set wins over a same-cycle clear.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n)      oOvf <= 1'b0;
        else if (ovf_set) oOvf <= 1'b1;
        else if (iOvfClr) oOvf <= 1'b0;
    end

    reg_rd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (iClk),
        .rst_n (iRst_n),
        .push  (push),
        .wdata (iRegData),
        .pop   (pop),
        .rdata (oRdData),
        .level (oLevel),
        .occ   (occ)
    );

    assign oRdValid = (occ != EMPTY);

endmodule

// File: doc/reg_read_port.md
REG_READ_PORT -- requirements
Module: reg_read_port

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the register data width.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the capture queue depth (power of two, at least 2).
REQ-003 The block SHALL have port iClk, input, 1, the single clock; all flops SHALL be on its rising edge.
REQ-004 The block SHALL have port iRst_n, input, 1, the reset; it SHALL be asynchronous and active-low.
REQ-005 The block SHALL have port iUpd, input, 1, a one-cycle pulse meaning the upstream register was written this cycle.
REQ-006 The block SHALL have port iRegData, input, DATA_W, the upstream register's current read value.
REQ-007 The block SHALL have port oRdValid, output, 1, meaning the head sample is available.
REQ-008 The block SHALL have port oRdData, output, DATA_W, the head sample.
REQ-009 The block SHALL have port iRdReady, input, 1, meaning the consumer accepts the head sample.
REQ-010 The block SHALL have port oLevel, output, $clog2(DEPTH)+1, the number of queued samples.
REQ-011 The block SHALL have port oOvf, output, 1, a sticky overflow flag.
REQ-012 The block SHALL have port iOvfClr, input, 1, a synchronous clear for oOvf.

Function
REQ-013 On iUpd=1, the block SHALL push the value of iRegData sampled one cycle after iUpd (the register's post-write value).
REQ-014 The queue SHALL be first-word-fall-through: a sample pushed into an empty queue SHALL appear on oRdValid/oRdData one cycle after capture.
REQ-015 A pop SHALL occur when oRdValid=1 and iRdReady=1 in the same cycle.
REQ-016 oRdData SHALL remain stable while oRdValid=1 and iRdReady=0.
REQ-017 The occupancy state SHALL be one of EMPTY, PARTIAL or FULL, derived from oLevel as 0, 1..DEPTH-1 or DEPTH respectively.
REQ-018 A push alone SHALL increment oLevel, a pop alone SHALL decrement it, and a simultaneous push and pop SHALL leave it unchanged.
REQ-019 When FULL, a push with a simultaneous pop SHALL succeed with no overflow.
REQ-020 When FULL, a push without a pop SHALL drop the new sample and set oOvf=1; the queued contents SHALL be unchanged.
REQ-021 A pop when EMPTY SHALL be impossible because oRdValid=0.
REQ-022 The read and write pointers SHALL wrap modulo DEPTH.
REQ-023 oOvf SHALL hold until iOvfClr=1; if iOvfClr=1 and a new overflow occur in the same cycle, oOvf SHALL end the cycle at 1 (set wins).
REQ-024 Back-to-back iUpd pulses on consecutive cycles SHALL each produce one push.

Reset
REQ-025 While iRst_n=0, the block SHALL force oRdValid=0, oRdData=0, oLevel=0, oOvf=0, both pointers to 0 and any pending capture to cleared.
REQ-026 An assertion of iRst_n=0 in the middle of an operation SHALL discard all queued samples and any pending iUpd capture.
REQ-027 Queue storage contents SHALL not need to be reset.

Configuration
REQ-028 The macro REG_READ_PORT_CHG_FILTER_EN SHALL control duplicate filtering.
REQ-029 With REG_READ_PORT_CHG_FILTER_EN defined, a capture SHALL be skipped when the captured value equals the last value pushed; the first capture after reset SHALL always be pushed.
REQ-030 With REG_READ_PORT_CHG_FILTER_EN undefined, every iUpd SHALL push, and the filter logic and its last-value register SHALL be absent.

Structure
REQ-031 Package reg_rd_pkg SHALL hold the default DATA_W and DEPTH constants and the typedef of the occupancy state enum (EMPTY, PARTIAL, FULL).
REQ-032 The storage and pointer logic SHALL be a sub-module named reg_rd_fifo; the capture, filter and overflow logic SHALL stay in the top module.

Verification
REQ-033 The bench SHALL apply: iUpd pulse with iRegData=8'hA5 after the write, iRdReady=0 -> oRdValid=1, oRdData=8'hA5 and oLevel=1 two cycles after the pulse, held stable.
REQ-034 The bench SHALL apply: 4 updates 8'h01..8'h04, then iRdReady=1 -> output sequence 01,02,03,04, with oLevel counting 4 down to 0.
REQ-035 The bench SHALL apply: 5 updates 8'h10..8'h14 with iRdReady=0 -> oOvf=1, oLevel=4, and reads return 10..13; then iOvfClr=1 -> oOvf=0.
REQ-036 The bench SHALL apply: FULL with simultaneous push 8'h55 and pop -> oOvf stays 0, oLevel stays 4, and 8'h55 is read last.
REQ-037 The bench SHALL apply: iRst_n=0 with oLevel=3 -> oRdValid=0 and oLevel=0 immediately (asynchronously), and after release no stale data appears.
REQ-038 The bench SHALL apply, with REG_READ_PORT_CHG_FILTER_EN defined: updates 8'h22, 8'h22, 8'h23 -> oLevel=2 and reads return 22, 23; with the macro undefined -> oLevel=3.
